// File: rtl/vape_cfg_pkg.sv
// Shared types and constants for the VAPE execution-range config controller.
// VAPE_CFG_IVT_LOCK_EN enables the IVT write/DMA lock while a run is live.
package vape_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_RUNNING = 3'd2,
        ST_DONE    = 3'd3,
        ST_ABORT   = 3'd4
    } state_e;

    localparam logic [15:0] CFG_BASE_DEF = 16'h0140;
    localparam logic [15:0] CFG_SPAN     = 16'd5;

    localparam logic [15:0] OFF_ER_MIN = 16'd0;
    localparam logic [15:0] OFF_ER_MAX = 16'd2;
    localparam logic [15:0] OFF_CTRL   = 16'd4;

    localparam int CTRL_ARM = 0;
    localparam int CTRL_CLR = 1;

    localparam logic [15:0] IVT_MIN = 16'hFFE0;
    localparam logic [15:0] IVT_MAX = 16'hFFFF;

    // Bounds must be word aligned and non-inverted before a run may be armed.
    function automatic logic bounds_ok(input logic [15:0] lo,
                                       input logic [15:0] hi);
        return (lo <= hi) && !lo[0] && !hi[0];
    endfunction

endpackage

// File: rtl/vape_cfg_decode.sv
// Combinational address decode: config window hits, word selects, IVT hits.
// IVT hits are only produced when VAPE_CFG_IVT_LOCK_EN is defined.
module vape_cfg_decode
    import vape_cfg_pkg::*;
#(
    parameter logic [15:0] CFG_BASE = CFG_BASE_DEF
) (
    input  logic [15:0] data_addr,
    input  logic        data_en,
    input  logic [15:0] dma_addr,
    input  logic        dma_en,
    output logic        cfg_hit_cpu,
    output logic        cfg_hit_dma,
    output logic        sel_min,
    output logic        sel_max,
    output logic        sel_ctrl,
    output logic        ivt_cpu,
    output logic        ivt_dma
);

    localparam logic [15:0] CFG_END = CFG_BASE + CFG_SPAN;
    localparam logic [15:0] A_MIN   = CFG_BASE + OFF_ER_MIN;
    localparam logic [15:0] A_MAX   = CFG_BASE + OFF_ER_MAX;
    localparam logic [15:0] A_CTRL  = CFG_BASE + OFF_CTRL;

    function automatic logic in_cfg(input logic [15:0] a);
        return (a >= CFG_BASE) && (a <= CFG_END);
    endfunction

    assign cfg_hit_cpu = data_en & in_cfg(data_addr);
    assign cfg_hit_dma = dma_en & in_cfg(dma_addr);

    // Word decode: both bytes of a register select it.
    assign sel_min  = (data_addr[15:1] == A_MIN[15:1]);
    assign sel_max  = (data_addr[15:1] == A_MAX[15:1]);
    assign sel_ctrl = (data_addr[15:1] == A_CTRL[15:1]);

`ifdef VAPE_CFG_IVT_LOCK_EN
    assign ivt_cpu = data_en & (data_addr >= IVT_MIN) & (data_addr <= IVT_MAX);
    assign ivt_dma = dma_en & (dma_addr >= IVT_MIN) & (dma_addr <= IVT_MAX);
`else
    assign ivt_cpu = 1'b0;
    assign ivt_dma = 1'b0;
`endif

endmodule

// File: rtl/vape_er_config_ctrl.sv
// ER bound registers and attested-execution sequencer for VAPE monitors.
// Optional IVT lock is built when VAPE_CFG_IVT_LOCK_EN is defined.
module vape_er_config_ctrl
    import vape_cfg_pkg::*;
#(
    parameter logic [15:0] CFG_BASE = CFG_BASE_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] pc,
    input  logic [15:0] data_addr,
    input  logic        data_en,
    input  logic        data_wr,
    input  logic [15:0] data_wdata,
    input  logic [15:0] dma_addr,
    input  logic        dma_en,
    input  logic        mon_ok,
    output logic [15:0] er_min,
    output logic [15:0] er_max,
    output logic        exec,
    output logic [2:0]  state_o,
    output logic        cfg_err
);

    state_e      state_q, state_d;
    logic [15:0] er_min_q, er_min_d;
    logic [15:0] er_max_q, er_max_d;
    logic        cfg_err_q, cfg_err_d;
    logic        exec_q, exec_d;

    logic cfg_hit_cpu, cfg_hit_dma;
    logic sel_min, sel_max, sel_ctrl;
    logic ivt_cpu, ivt_dma;

    vape_cfg_decode #(
        .CFG_BASE (CFG_BASE)
    ) u_decode (
        .data_addr   (data_addr),
        .data_en     (data_en),
        .dma_addr    (dma_addr),
        .dma_en      (dma_en),
        .cfg_hit_cpu (cfg_hit_cpu),
        .cfg_hit_dma (cfg_hit_dma),
        .sel_min     (sel_min),
        .sel_max     (sel_max),
        .sel_ctrl    (sel_ctrl),
        .ivt_cpu     (ivt_cpu),
        .ivt_dma     (ivt_dma)
    );

    logic cpu_wr, wr_min, wr_max, wr_ctrl;
    logic arm, clr, tamper, live, viol;

    assign cpu_wr  = cfg_hit_cpu & data_wr;
    assign wr_min  = cpu_wr & sel_min;
    assign wr_max  = cpu_wr & sel_max;
    assign wr_ctrl = cpu_wr & sel_ctrl;
    assign clr     = wr_ctrl & data_wdata[CTRL_CLR];
    assign arm     = wr_ctrl & data_wdata[CTRL_ARM] & ~data_wdata[CTRL_CLR];

    // Config tampering counts after arming; monitor/IVT only while live.
    assign tamper = cfg_hit_dma | wr_min | wr_max;
    assign live   = (state_q == ST_ARMED) | (state_q == ST_RUNNING);
    assign viol   = (live & (tamper | ~mon_ok | (data_wr & ivt_cpu) | ivt_dma))
                  | ((state_q == ST_DONE) & tamper);

    always_comb begin
        state_d   = state_q;
        er_min_d  = er_min_q;
        er_max_d  = er_max_q;
        cfg_err_d = cfg_err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (wr_min) er_min_d = data_wdata;
                if (wr_max) er_max_d = data_wdata;
                if (clr) begin
                    cfg_err_d = 1'b0;
                end else if (arm) begin
                    if (bounds_ok(er_min_q, er_max_q)) state_d = ST_ARMED;
                    else cfg_err_d = 1'b1;
                end
            end
            ST_ARMED: begin
                if (viol) state_d = ST_ABORT;
                else if (clr) state_d = ST_IDLE;
                else if (pc == er_min_q) state_d = ST_RUNNING;
            end
            ST_RUNNING: begin
                if (viol) state_d = ST_ABORT;
                else if (clr) state_d = ST_IDLE;
                else if (pc == er_max_q) state_d = ST_DONE;
                else if ((pc < er_min_q) || (pc > er_max_q)) state_d = ST_ABORT;
            end
            ST_DONE: begin
                if (viol) state_d = ST_ABORT;
                else if (clr) state_d = ST_IDLE;
                else if (pc == er_min_q) state_d = ST_RUNNING;
            end
            ST_ABORT: begin
                if (clr) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        exec_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            er_min_q  <= 16'h0000;
            er_max_q  <= 16'h0000;
            cfg_err_q <= 1'b0;
            exec_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            er_min_q  <= er_min_d;
            er_max_q  <= er_max_d;
            cfg_err_q <= cfg_err_d;
            exec_q    <= exec_d;
        end
    end

    assign er_min  = er_min_q;
    assign er_max  = er_max_q;
    assign exec    = exec_q;
    assign state_o = state_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_vape_er_config_ctrl.sv
// Self-checking bench for vape_er_config_ctrl: directed table plus
// randomized traffic against a behavioural reference model.
module tb_vape_er_config_ctrl;

    localparam int S_IDLE = 0, S_ARMED = 1, S_RUN = 2, S_DONE = 3, S_ABORT = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] pc, data_addr, data_wdata, dma_addr;
    logic        data_en, data_wr, dma_en, mon_ok;
    logic [15:0] er_min, er_max;
    logic        exec, cfg_err;
    logic [2:0]  state_o;

    vape_er_config_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pc         (pc),
        .data_addr  (data_addr),
        .data_en    (data_en),
        .data_wr    (data_wr),
        .data_wdata (data_wdata),
        .dma_addr   (dma_addr),
        .dma_en     (dma_en),
        .mon_ok     (mon_ok),
        .er_min     (er_min),
        .er_max     (er_max),
        .exec       (exec),
        .state_o    (state_o),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    int          m_state;
    logic [15:0] m_min, m_max;
    bit          m_err, m_exec;

    typedef struct {
        logic [15:0] pc;
        bit          we;
        logic [15:0] a;
        logic [15:0] d;
        bit          dma;
        logic [15:0] da;
        bit          ok;
        int          st;
        bit          ex;
        bit          er;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t V(logic [15:0] p, bit we, logic [15:0] a,
                               logic [15:0] d, bit dma, logic [15:0] da,
                               bit ok, int st, bit ex, bit er);
        vec_t v;
        v.pc = p; v.we = we; v.a = a; v.d = d; v.dma = dma; v.da = da;
        v.ok = ok; v.st = st; v.ex = ex; v.er = er;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] got,
                       input logic [15:0] want);
        n_chk++;
        if (got !== want)
            $display("FAIL %s: got %0h required %0h", nm, got, want);
        else
            n_pass++;
    endtask

    task automatic idle_inputs();
        pc = 16'h0; data_addr = 16'h0; data_wdata = 16'h0;
        dma_addr = 16'h0; data_en = 0; data_wr = 0; dma_en = 0; mon_ok = 1;
    endtask

    task automatic model_reset();
        m_state = S_IDLE; m_min = 0; m_max = 0; m_err = 0; m_exec = 0;
    endtask

    // Reference: one clock of the attestation rules, evaluated on the inputs.
    task automatic model_step();
        int  a, da;
        bit  w, h_min, h_max, h_ctl, h_dma, arm, clr, ivt, bad;
        a     = int'(data_addr);
        da    = int'(dma_addr);
        w     = data_en && data_wr;
        h_min = w && (a == 'h140 || a == 'h141);
        h_max = w && (a == 'h142 || a == 'h143);
        h_ctl = w && (a == 'h144 || a == 'h145);
        h_dma = dma_en && da >= 'h140 && da <= 'h145;
        clr   = h_ctl && data_wdata[1];
        arm   = h_ctl && data_wdata[0] && !clr;
        ivt   = 0;
`ifdef VAPE_CFG_IVT_LOCK_EN
        ivt = (w && a >= 'hFFE0) || (dma_en && da >= 'hFFE0);
`endif
        if (m_state == S_IDLE) begin
            if (h_min) m_min = data_wdata;
            if (h_max) m_max = data_wdata;
            if (clr) m_err = 0;
            else if (arm) begin
                if (m_min <= m_max && m_min % 2 == 0 && m_max % 2 == 0)
                    m_state = S_ARMED;
                else
                    m_err = 1;
            end
        end else begin
            bad = h_dma || h_min || h_max;
            if (m_state == S_ARMED || m_state == S_RUN) bad = bad || !mon_ok || ivt;
            if (m_state == S_ABORT) bad = 0;
            if (bad) m_state = S_ABORT;
            else if (clr) m_state = S_IDLE;
            else if (m_state == S_ARMED && pc == m_min) m_state = S_RUN;
            else if (m_state == S_DONE && pc == m_min) m_state = S_RUN;
            else if (m_state == S_RUN) begin
                if (pc == m_max) m_state = S_DONE;
                else if (pc < m_min || pc > m_max) m_state = S_ABORT;
            end
        end
        m_exec = (m_state == S_DONE);
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, " state"},   16'(state_o), 16'(m_state));
        chk({tag, " exec"},    16'(exec),    16'(m_exec));
        chk({tag, " cfg_err"}, 16'(cfg_err), 16'(m_err));
        chk({tag, " er_min"},  er_min,       m_min);
        chk({tag, " er_max"},  er_max,       m_max);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        cmp_model(tag);
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        idle_inputs();
        data_en = 1; data_wr = 1; data_addr = a; data_wdata = d;
    endtask

    int exp6;
    int r, span;

    initial begin
        idle_inputs();
        reset_n = 0;
        model_reset();
        #3;
        chk("reset state",   16'(state_o), 16'd0);
        chk("reset er_min",  er_min, 16'h0);
        chk("reset er_max",  er_max, 16'h0);
        chk("reset exec",    16'(exec), 16'd0);
        chk("reset cfg_err", 16'(cfg_err), 16'd0);
        @(negedge clk);
        reset_n = 1;

        tbl.push_back(V(0, 1, 'h140, 'hE000, 0, 0, 1, 0, 0, 0));
        tbl.push_back(V(0, 1, 'h142, 'hE0FE, 0, 0, 1, 0, 0, 0));
        tbl.push_back(V(0, 1, 'h144, 'h0001, 0, 0, 1, 1, 0, 0));
        tbl.push_back(V('hE000, 0, 0, 0, 0, 0, 1, 2, 0, 0));
        tbl.push_back(V('hE002, 0, 0, 0, 0, 0, 1, 2, 0, 0));
        tbl.push_back(V('hE080, 0, 0, 0, 0, 0, 1, 2, 0, 0));
        tbl.push_back(V('hE0FC, 0, 0, 0, 0, 0, 1, 2, 0, 0));
        tbl.push_back(V('hE0FE, 0, 0, 0, 0, 0, 1, 3, 1, 0));
        tbl.push_back(V('hE0FE, 0, 0, 0, 0, 0, 1, 3, 1, 0));
        tbl.push_back(V('hE000, 0, 0, 0, 0, 0, 1, 2, 0, 0));
        tbl.push_back(V('hF000, 0, 0, 0, 0, 0, 1, 4, 0, 0));
        tbl.push_back(V(0, 1, 'h144, 'h0002, 0, 0, 1, 0, 0, 0));
        tbl.push_back(V(0, 1, 'h140, 'hE100, 0, 0, 1, 0, 0, 0));
        tbl.push_back(V(0, 1, 'h142, 'hE000, 0, 0, 1, 0, 0, 0));
        tbl.push_back(V(0, 1, 'h144, 'h0001, 0, 0, 1, 0, 0, 1));
        tbl.push_back(V(0, 1, 'h144, 'h0002, 0, 0, 1, 0, 0, 0));
        tbl.push_back(V(0, 1, 'h140, 'hE000, 0, 0, 1, 0, 0, 0));
        tbl.push_back(V(0, 1, 'h144, 'h0003, 0, 0, 1, 0, 0, 0));
        tbl.push_back(V(0, 1, 'h142, 'hE0FE, 0, 0, 1, 0, 0, 0));
        tbl.push_back(V(0, 1, 'h144, 'h0001, 0, 0, 1, 1, 0, 0));
        tbl.push_back(V(0, 1, 'h144, 'h0001, 0, 0, 1, 1, 0, 0));
        tbl.push_back(V('hE000, 0, 0, 0, 0, 0, 1, 2, 0, 0));
        tbl.push_back(V('hE010, 0, 0, 0, 1, 'h142, 1, 4, 0, 0));
        tbl.push_back(V('hE000, 0, 0, 0, 0, 0, 1, 4, 0, 0));
        tbl.push_back(V(0, 1, 'h144, 'h0002, 0, 0, 1, 0, 0, 0));
        tbl.push_back(V(0, 1, 'h144, 'h0001, 0, 0, 1, 1, 0, 0));
        tbl.push_back(V('hE000, 0, 0, 0, 0, 0, 1, 2, 0, 0));
        tbl.push_back(V('hE0FE, 0, 0, 0, 0, 0, 0, 4, 0, 0));
        tbl.push_back(V(0, 1, 'h144, 'h0002, 0, 0, 1, 0, 0, 0));
        tbl.push_back(V(0, 1, 'h144, 'h0001, 0, 0, 1, 1, 0, 0));
        tbl.push_back(V('hE000, 0, 0, 0, 0, 0, 1, 2, 0, 0));
        tbl.push_back(V('hE0FE, 0, 0, 0, 0, 0, 1, 3, 1, 0));
        tbl.push_back(V('hE0FE, 0, 0, 0, 0, 0, 0, 3, 1, 0));
        tbl.push_back(V(0, 0, 0, 0, 1, 'h145, 1, 4, 0, 0));
        tbl.push_back(V(0, 1, 'h144, 'h0002, 0, 0, 1, 0, 0, 0));
        tbl.push_back(V(0, 1, 'h140, 'hE003, 0, 0, 1, 0, 0, 0));
        tbl.push_back(V(0, 1, 'h144, 'h0001, 0, 0, 1, 0, 0, 1));
        tbl.push_back(V(0, 1, 'h144, 'h0002, 0, 0, 1, 0, 0, 0));
        tbl.push_back(V(0, 1, 'h140, 'hE004, 0, 0, 1, 0, 0, 0));
        tbl.push_back(V(0, 1, 'h142, 'hE004, 0, 0, 1, 0, 0, 0));
        tbl.push_back(V(0, 1, 'h144, 'h0001, 0, 0, 1, 1, 0, 0));
        tbl.push_back(V('hE004, 0, 0, 0, 0, 0, 1, 2, 0, 0));
        tbl.push_back(V('hE004, 0, 0, 0, 0, 0, 1, 3, 1, 0));
        tbl.push_back(V(0, 1, 'h144, 'h0002, 0, 0, 1, 0, 0, 0));
        tbl.push_back(V(0, 1, 'h144, 'h0001, 0, 0, 1, 1, 0, 0));
        tbl.push_back(V('hE004, 0, 0, 0, 0, 0, 1, 2, 0, 0));

        @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            idle_inputs();
            pc = tbl[i].pc;
            data_en = tbl[i].we; data_wr = tbl[i].we;
            data_addr = tbl[i].a; data_wdata = tbl[i].d;
            dma_en = tbl[i].dma; dma_addr = tbl[i].da;
            mon_ok = tbl[i].ok;
            tick($sformatf("vec%0d model", i));
            chk($sformatf("vec%0d state", i),   16'(state_o), 16'(tbl[i].st));
            chk($sformatf("vec%0d exec", i),    16'(exec),    16'(tbl[i].ex));
            chk($sformatf("vec%0d cfg_err", i), 16'(cfg_err), 16'(tbl[i].er));
        end

        // Asynchronous reset while RUNNING.
        idle_inputs();
        pc = 16'hE004;
        #2 reset_n = 0;
        #1;
        model_reset();
        chk("midrun reset state",  16'(state_o), 16'd0);
        chk("midrun reset er_min", er_min, 16'h0);
        chk("midrun reset er_max", er_max, 16'h0);
        chk("midrun reset exec",   16'(exec), 16'd0);
        @(negedge clk);
        reset_n = 1;

        // IVT write while ARMED.
        wr('h140, 'hE000); tick("ivt setup0");
        wr('h142, 'hE0FE); tick("ivt setup1");
        wr('h144, 'h0001); tick("ivt setup2");
        chk("ivt armed", 16'(state_o), 16'd1);
        wr('hFFFE, 'h1234); tick("ivt write");
`ifdef VAPE_CFG_IVT_LOCK_EN
        exp6 = S_ABORT;
`else
        exp6 = S_ARMED;
`endif
        chk("ivt write state", 16'(state_o), 16'(exp6));
        wr('h144, 'h0002); tick("ivt clr");
        chk("ivt clr state", 16'(state_o), 16'd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            idle_inputs();
            data_wdata = 16'($urandom);
            r = $urandom_range(0, 99);
            if (r < 10) begin
                data_en = 1; data_wr = 1;
                data_addr = 16'h140 + 16'($urandom_range(0, 5));
                if (data_addr >= 16'h144)
                    data_wdata = 16'($urandom_range(0, 3));
                else
                    data_wdata = 16'h2000 + 16'(2 * $urandom_range(0, 8))
                               + 16'($urandom_range(0, 7) == 0);
            end else if (r < 13) begin
                dma_en = 1;
                dma_addr = ($urandom_range(0, 2) == 0)
                         ? 16'h140 + 16'($urandom_range(0, 5))
                         : 16'($urandom);
            end else if (r < 15) begin
                mon_ok = 0;
            end else if (r < 17) begin
                data_en = 1; data_wr = 1;
                data_addr = ($urandom_range(0, 1) == 0)
                          ? 16'hFFE0 + 16'($urandom_range(0, 31))
                          : 16'h0200 + 16'($urandom_range(0, 255));
            end else if (r < 20) begin
                data_en = 1; data_wr = 0;
                data_addr = 16'h140 + 16'($urandom_range(0, 5));
            end
            r = $urandom_range(0, 9);
            if (m_max >= m_min) span = (int'(m_max) - int'(m_min)) / 2;
            else span = 0;
            if (r < 3) pc = m_min;
            else if (r < 5) pc = m_max;
            else if (r < 9) pc = m_min + 16'(2 * $urandom_range(0, span));
            else pc = 16'($urandom);
            tick($sformatf("rand%0d", c));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vape_er_config_ctrl.md
Name: vape_er_config_ctrl

Overview:
- Memory-mapped configuration and sequencing controller for the VAPE-style execution-range (ER) monitors.
- Holds the ER_min/ER_max bounds that the protection monitors consume, and freezes them once armed.
- Tracks a single attested execution: arm, entry at ER_min, exit at ER_max.
- Produces the registered exec proof flag; any tampering with configuration or monitor violations during the run kills it.

Parameters:
- CFG_BASE, 16'h0140: byte base of config window. ER_MIN at +0, ER_MAX at +2, CTRL at +4.
- IVT_MIN, 16'hFFE0: low bound of the interrupt vector table (used only by the optional feature).
- IVT_MAX, 16'hFFFF: high bound of the interrupt vector table (used only by the optional feature).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- pc  in  16  current CPU program counter
- data_addr  in  16  CPU data address
- data_en  in  1  CPU data access strobe
- data_wr  in  1  CPU access is a write (qualifies data_en)
- data_wdata  in  16  CPU write data
- dma_addr  in  16  DMA address
- dma_en  in  1  DMA access strobe
- mon_ok  in  1  AND of downstream monitor exec flags; 0 means violation
- er_min  out  16  frozen ER lower bound
- er_max  out  16  frozen ER upper bound
- exec  out  1  attested-execution flag
- state_o  out  3  FSM state: IDLE=0, ARMED=1, RUNNING=2, DONE=3, ABORT=4
- cfg_err  out  1  sticky flag: invalid ARM attempt

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE, er_min=16'h0000, er_max=16'h0000, exec=0, cfg_err=0.
- All outputs are registered; each reacts one cycle after the causing input.
- Window hit definitions:
  - cfg_hit_cpu = data_en & (data_addr in [CFG_BASE, CFG_BASE+5]).
  - cfg_hit_dma = dma_en & (dma_addr in the same range).
- CPU writes decode word address: data_addr[15:1] == (CFG_BASE+n)>>1. CPU reads are not served by this block.
- CTRL write bits:
  - bit0 = ARM.
  - bit1 = CLR.
  - Other bits are ignored.
- Config writes:
  - ER_MIN and ER_MAX are writable only in IDLE.
  - In IDLE a DMA hit is ignored; register contents are unchanged.
- Violation term viol:
  - In ARMED, RUNNING or DONE: any cfg_hit_dma, or any CPU write to ER_MIN/ER_MAX.
  - In ARMED or RUNNING: additionally mon_ok==0.
- Transition priority, highest first: reset > viol > CLR > pc-based transitions.
- IDLE:
  - ARM with er_min<=er_max, er_min[0]==0 and er_max[0]==0 -> ARMED.
  - ARM with invalid bounds -> stay IDLE, set cfg_err.
  - CLR clears cfg_err.
- ARMED:
  - pc==er_min -> RUNNING.
  - CLR -> IDLE.
  - viol -> ABORT.
- RUNNING:
  - pc==er_max -> DONE, exec=1.
  - pc outside [er_min, er_max] -> ABORT.
  - viol -> ABORT.
- DONE:
  - exec held at 1.
  - pc==er_min -> RUNNING, exec=0 (re-execution restarts the proof).
  - viol -> ABORT, exec=0.
  - CLR -> IDLE, exec=0.
- ABORT:
  - exec=0.
  - Only CLR exits, to IDLE; pc==er_min does not re-arm.
- Boundary cases:
  - A CTRL write with ARM=1 and CLR=1 together is treated as CLR.
  - ARM in any state other than IDLE is ignored.
  - er_min==er_max is legal; ARMED goes to RUNNING on pc==er_min, then DONE on the next cycle if pc is still equal.
  - viol on the same cycle as pc==er_max -> ABORT; exec stays 0.
  - Deassertion of reset_n is treated as synchronous to clk by the upstream reset synchronizer.

Optional Feature:
- Macro: VAPE_CFG_IVT_LOCK_EN.
- Defined: in ARMED and RUNNING, a CPU write or DMA access with address in [IVT_MIN, IVT_MAX] is an additional viol term (-> ABORT).
- Undefined: IVT accesses are ignored by this block; IVT_MIN and IVT_MAX are unused.

Decomposition:
- Shared package vape_cfg_pkg contains:
  - state encoding constants.
  - register offsets (OFF_ER_MIN=0, OFF_ER_MAX=2, OFF_CTRL=4).
  - CTRL bit positions.
- One sub-module, vape_cfg_decode: purely combinational address and window decode for cfg_hit_cpu, cfg_hit_dma, register selects and the IVT hit.
- The FSM and register file stay in the top block.

Test Plan:
1. Write ER_MIN=0xE000, ER_MAX=0xE0FE, CTRL=0x1; pc=0xE000, then 0xE002..0xE0FE -> state ARMED->RUNNING->DONE, exec=1 one cycle after pc=0xE0FE.
2. Write ER_MIN=0xE100, ER_MAX=0xE000, ARM -> state stays IDLE, cfg_err=1. Then CTRL=0x2 -> cfg_err=0.
3. During RUNNING (pc=0xE010), dma_en=1 with dma_addr=0x0142 -> ABORT next cycle, exec=0. Then pc=0xE000 -> remains ABORT. CTRL=0x2 -> IDLE.
4. In DONE, pc=0xE000 -> RUNNING and exec=0. In RUNNING, pc jumps to 0xF000 -> ABORT.
5. In RUNNING, mon_ok=0 on the same cycle as pc==0xE0FE -> ABORT, exec never rises. Assert reset_n=0 mid-RUNNING -> immediately IDLE, er_min=er_max=0.
6. With VAPE_CFG_IVT_LOCK_EN defined: in ARMED, CPU write to 0xFFFE -> ABORT. Without the macro, the same stimulus leaves the state ARMED.
